// File: rtl/program_loader.sv
// SAP-1 front-panel programming sequencer: turns switches plus a deposit button into a
// load-address / write / release sequence. Define LOADER_AUTOINC_EN for an auto-incrementing address.
module program_loader #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              run_sw,
  input  logic [ADDR_W-1:0] addr_sw,
  input  logic [DATA_W-1:0] data_sw,
  input  logic              deposit,
  input  logic              set_addr,
  output logic              prog,
  output logic              nLm,
  output logic [ADDR_W-1:0] mar_in,
  output logic [DATA_W-1:0] ram_din,
  output logic              nwe,
  output logic              busy,
  output logic              wr_done
);

  localparam logic [2:0] StRun     = 3'd0;
  localparam logic [2:0] StPgmIdle = 3'd1;
  localparam logic [2:0] StLdAddr  = 3'd2;
  localparam logic [2:0] StWrite   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [3:0] WrLast = 4'(WR_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              deposit_q;
  logic              dep_edge;
  logic [ADDR_W-1:0] dep_addr;

  logic              prog_q, prog_d;
  logic              nlm_q, nlm_d;
  logic              nwe_q, nwe_d;
  logic              busy_q, busy_d;
  logic              wr_done_q, wr_done_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] din_q, din_d;

  assign dep_edge = deposit & ~deposit_q;

`ifdef LOADER_AUTOINC_EN
  logic              set_addr_q;
  logic              set_edge;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

  assign set_edge = set_addr & ~set_addr_q;
  assign dep_addr = cur_addr_q;

  // Deposits use the pre-load address if set_addr and deposit rise together.
  always_comb begin
    cur_addr_d = cur_addr_q;
    if (state_q == StPgmIdle && set_edge) begin
      cur_addr_d = addr_sw;
    end else if (state_q == StDone) begin
      cur_addr_d = cur_addr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      set_addr_q <= 1'b0;
      cur_addr_q <= '0;
    end else begin
      set_addr_q <= set_addr;
      cur_addr_q <= cur_addr_d;
    end
  end
`else
  logic unused_set_addr;
  assign unused_set_addr = set_addr;
  assign dep_addr        = addr_sw;
`endif

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    mar_d    = mar_q;
    din_d    = din_q;
    unique case (state_q)
      StRun: begin
        if (!run_sw) state_d = StPgmIdle;
      end
      StPgmIdle: begin
        if (run_sw) begin
          state_d = StRun;
        end else if (dep_edge) begin
          state_d = StLdAddr;
          mar_d   = dep_addr;
          din_d   = data_sw;
        end
      end
      StLdAddr: begin
        state_d  = StWrite;
        wr_cnt_d = '0;
      end
      StWrite: begin
        if (wr_cnt_q == WrLast) begin
          state_d = StDone;
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = run_sw ? StRun : StPgmIdle;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    prog_d    = (state_d == StRun);
    nlm_d     = (state_d != StLdAddr);
    nwe_d     = (state_d != StWrite);
    busy_d    = (state_d == StLdAddr) || (state_d == StWrite) || (state_d == StDone);
    wr_done_d = (state_d == StDone);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= StRun;
      wr_cnt_q  <= '0;
      deposit_q <= 1'b0;
      prog_q    <= 1'b1;
      nlm_q     <= 1'b1;
      nwe_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_done_q <= 1'b0;
      mar_q     <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      deposit_q <= deposit;
      prog_q    <= prog_d;
      nlm_q     <= nlm_d;
      nwe_q     <= nwe_d;
      busy_q    <= busy_d;
      wr_done_q <= wr_done_d;
      mar_q     <= mar_d;
      din_q     <= din_d;
    end
  end

  assign prog    = prog_q;
  assign nLm     = nlm_q;
  assign nwe     = nwe_q;
  assign busy    = busy_q;
  assign wr_done = wr_done_q;
  assign mar_in  = mar_q;
  assign ram_din = din_q;

  // The MAR load and the RAM write must never overlap; prog stays low for a whole sequence.
  a_no_overlap: assert property (@(posedge CLK) disable iff (CLR) !(!nLm && !nwe));
  a_prog_low:   assert property (@(posedge CLK) disable iff (CLR) busy |-> !prog);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a sequence-offset reference model predicts every
// output each cycle. Autoinc checks are built only when LOADER_AUTOINC_EN is defined.
module tb_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int WR = 2;
`ifdef LOADER_AUTOINC_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic          run_sw = 1'b1;
  logic [AW-1:0] addr_sw = '0;
  logic [DW-1:0] data_sw = '0;
  logic          deposit = 1'b0;
  logic          set_addr = 1'b0;
  logic          prog, nLm, nwe, busy, wr_done;
  logic [AW-1:0] mar_in;
  logic [DW-1:0] ram_din;

  program_loader #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR)) dut (
    .CLK(CLK), .CLR(CLR), .run_sw(run_sw), .addr_sw(addr_sw), .data_sw(data_sw),
    .deposit(deposit), .set_addr(set_addr), .prog(prog), .nLm(nLm), .mar_in(mar_in),
    .ram_din(ram_din), .nwe(nwe), .busy(busy), .wr_done(wr_done)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: m_off is the cycle offset since the accepted deposit edge (-1 when no sequence).
  bit            m_run = 1'b1;
  int            m_off = -1;
  logic [AW-1:0] m_mar = '0, m_cur = '0;
  logic [DW-1:0] m_din = '0;
  bit            m_dep_prev = 1'b0, m_set_prev = 1'b0;
  logic [16:0]   exp_vec;

  function automatic logic [16:0] obs();
    return {prog, nLm, nwe, busy, wr_done, mar_in, ram_din};
  endfunction

  task automatic tick();
    bit dep_edge, set_edge;
    @(posedge CLK);
    cyc++;
    dep_edge = deposit && !m_dep_prev;
    set_edge = set_addr && !m_set_prev;
    if (CLR) begin
      m_run = 1'b1; m_off = -1; m_mar = '0; m_din = '0; m_cur = '0;
      m_dep_prev = 1'b0; m_set_prev = 1'b0;
    end else begin
      if (m_off == 2 + WR) begin
        m_off = -1;
        m_run = run_sw;
        if (Auto) m_cur = AW'((int'(m_cur) + 1) % (1 << AW));
      end else if (m_off >= 1) begin
        m_off++;
      end else if (m_run) begin
        if (!run_sw) m_run = 1'b0;
      end else begin
        if (run_sw) begin
          m_run = 1'b1;
        end else if (dep_edge) begin
          m_off = 1;
          m_mar = Auto ? m_cur : addr_sw;
          m_din = data_sw;
        end
        if (Auto && set_edge) m_cur = addr_sw;
      end
      m_dep_prev = deposit;
      m_set_prev = set_addr;
    end
    exp_vec = {(m_run && m_off < 0), (m_off != 1), !(m_off >= 2 && m_off <= 1 + WR),
               (m_off >= 1), (m_off == 2 + WR), m_mar, m_din};
    @(negedge CLK);
  endtask

  task automatic test_reset();
    CLR = 1'b1; run_sw = 1'b1;
    tick(); tick();
    n_cmp++;
    if (obs() !== 17'h1C000) begin
      n_fail++; $display("FAIL reset_values got=%h want=%h", obs(), 17'h1C000);
    end
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL reset_run cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
    end
    n_cmp++;
    if (prog !== 1'b1) begin n_fail++; $display("FAIL run_prog got=%b want=1", prog); end
    run_sw = 1'b0;
    tick();
    n_cmp++;
    if (prog !== 1'b0) begin n_fail++; $display("FAIL pgm_prog got=%b want=0", prog); end
    tick();
  endtask

  task automatic test_basic();
    int n_busy = 0, n_nwe = 0, n_nlm = 0, n_done = 0;
    addr_sw = 4'hC; data_sw = 8'hA5; deposit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      deposit = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
      n_busy += int'(busy); n_nwe += int'(!nwe); n_done += int'(wr_done);
      if (!nLm) begin
        n_nlm++;
        n_cmp++;
        if (mar_in !== 4'hC) begin n_fail++; $display("FAIL basic_mar got=%h want=c", mar_in); end
      end
      if (!nwe) begin
        n_cmp++;
        if (ram_din !== 8'hA5) begin n_fail++; $display("FAIL basic_din got=%h want=a5", ram_din); end
      end
    end
    n_cmp++;
    if (n_busy != 4 || n_nwe != WR || n_nlm != 1 || n_done != 1) begin
      n_fail++;
      $display("FAIL basic_counts got busy=%0d nwe=%0d nlm=%0d done=%0d want 4/%0d/1/1",
               n_busy, n_nwe, n_nlm, n_done, WR);
    end
  endtask

  task automatic test_held();
    int n_done = 0;
    addr_sw = 4'h3; data_sw = 8'h5A; deposit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL held cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
      n_done += int'(wr_done);
    end
    n_cmp++;
    if (n_done != 1) begin n_fail++; $display("FAIL held_writes got=%0d want=1", n_done); end
    // Release, then re-press once the sequence is in WRITE.
    deposit = 1'b0; tick();
    n_done = 0;
    deposit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) deposit = 1'b0;
      if (i == 1) deposit = 1'b1;
      if (i == 2) deposit = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL extra cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
      n_done += int'(wr_done);
    end
    n_cmp++;
    if (n_done != 1) begin n_fail++; $display("FAIL extra_writes got=%0d want=1", n_done); end
  endtask

  task automatic test_switch_exit();
    int n_nwe = 0, done_at = -1, i_prog = -1;
    addr_sw = 4'hC; data_sw = 8'hA5; deposit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      deposit = 1'b0;
      if (i == 1) begin
        addr_sw = AW'($urandom_range(0, 11)); data_sw = 8'h3C; run_sw = 1'b1;
      end
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL switch cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
      if (!nwe) begin
        n_nwe++;
        n_cmp++;
        if ({mar_in, ram_din} !== 12'hCA5) begin
          n_fail++; $display("FAIL switch_latch got=%h want=ca5", {mar_in, ram_din});
        end
      end
      if (wr_done) done_at = i;
      if (prog && i_prog < 0 && i > 0) i_prog = i;
    end
    n_cmp++;
    if (n_nwe != WR || done_at < 0 || i_prog != done_at + 1) begin
      n_fail++;
      $display("FAIL switch_exit got nwe=%0d done_at=%0d prog_at=%0d want nwe=%0d prog one after done",
               n_nwe, done_at, i_prog, WR);
    end
  endtask

  task automatic test_reset_mid();
    run_sw = 1'b0; tick(); tick();
    data_sw = 8'h77; deposit = 1'b1;
    tick(); deposit = 1'b0;
    tick();
    n_cmp++;
    if (nwe !== 1'b0) begin n_fail++; $display("FAIL midreset_pre nwe got=%b want=0", nwe); end
    CLR = 1'b1;
    tick();
    n_cmp++;
    if ({nwe, nLm, prog, busy, wr_done} !== 5'b11100) begin
      n_fail++; $display("FAIL midreset got=%b want=11100", {nwe, nLm, prog, busy, wr_done});
    end
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL midreset_after cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) deposit = ~deposit;
      if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 5) == 0) set_addr = ~set_addr;
      CLR = ($urandom_range(0, 99) == 0);
      addr_sw = AW'($urandom);
      data_sw = DW'($urandom);
      tick();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
      end
    end
    CLR = 1'b0; deposit = 1'b0; set_addr = 1'b0;
  endtask

`ifdef LOADER_AUTOINC_EN
  task automatic test_autoinc();
    logic [7:0]    datas [4];
    logic [AW-1:0] wants [4];
    datas = '{8'h11, 8'h22, 8'h33, 8'h44};
    wants = '{4'hE, 4'hF, 4'h0, 4'h1};
    run_sw = 1'b0; tick(); tick();
    addr_sw = 4'hE; set_addr = 1'b1; tick(); set_addr = 1'b0; tick();
    for (int d = 0; d < 4; d++) begin
      addr_sw = AW'($urandom); data_sw = datas[d]; deposit = 1'b1;
      for (int i = 0; i < 3 + WR; i++) begin
        tick();
        deposit = 1'b0;
        n_cmp++;
        if (obs() !== exp_vec) begin
          n_fail++; $display("FAIL autoinc cyc=%0d got=%h want=%h", cyc, obs(), exp_vec);
        end
        if (!nLm) begin
          n_cmp++;
          if ({mar_in, ram_din} !== {wants[d], datas[d]}) begin
            n_fail++;
            $display("FAIL autoinc_addr got=%h want=%h", {mar_in, ram_din}, {wants[d], datas[d]});
          end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_switch_exit();
    test_reset_mid();
`ifdef LOADER_AUTOINC_EN
    test_autoinc();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
